// File: rtl/wb_pkg.sv
// Shared types and encodings for the writeback-select pipe.
// Optional feature macro: WB_CSR_EN (CSR class writes back through its own select).
package wb_pkg;

    localparam int WB_CODE_W    = 10;
    localparam int WB_RD_W      = 5;
    localparam int WB_SEL_MAX_W = 8;

    localparam int CODE_J     = 0;
    localparam int CODE_JALR  = 1;
    localparam int CODE_LUI   = 2;
    localparam int CODE_AUIPC = 3;
    localparam int CODE_B     = 4;
    localparam int CODE_R     = 5;
    localparam int CODE_S     = 6;
    localparam int CODE_IALU  = 7;
    localparam int CODE_LOAD  = 8;
    localparam int CODE_CSR   = 9;

    localparam logic [WB_SEL_MAX_W-1:0] WB_SEL_MEM = 8'd0;
    localparam logic [WB_SEL_MAX_W-1:0] WB_SEL_IMM = 8'd1;
    localparam logic [WB_SEL_MAX_W-1:0] WB_SEL_ALU = 8'd2;
    localparam logic [WB_SEL_MAX_W-1:0] WB_SEL_PC4 = 8'd3;
    localparam logic [WB_SEL_MAX_W-1:0] WB_SEL_CSR = 8'd4;

    // Select is stored at its widest legal size; the pipe truncates to SEL_W.
    typedef struct packed {
        logic                    valid;
        logic [WB_SEL_MAX_W-1:0] sel;
        logic                    we;
        logic [WB_RD_W-1:0]      rd;
        logic                    is_load;
        logic                    illegal;
    } wb_entry_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational instruction-class decoder: one-hot class -> {sel, we, is_load, illegal}.
// Optional feature macro: WB_CSR_EN.
module wb_decode
    import wb_pkg::*;
(
    input  logic [WB_CODE_W-1:0]    code,
    input  logic [WB_RD_W-1:0]      rd,
    output logic [WB_SEL_MAX_W-1:0] sel,
    output logic                    we,
    output logic                    is_load,
    output logic                    illegal
);

    logic one_hot;

    always_comb begin
        one_hot = (code != '0) && ((code & (code - 10'd1)) == '0);
        sel     = WB_SEL_MEM;
        we      = 1'b0;
        is_load = 1'b0;
        illegal = ~one_hot;

        if (one_hot) begin
            if (code[CODE_J] | code[CODE_JALR]) begin
                sel = WB_SEL_PC4;
                we  = 1'b1;
            end
            if (code[CODE_LUI]) begin
                sel = WB_SEL_IMM;
                we  = 1'b1;
            end
            if (code[CODE_AUIPC] | code[CODE_R] | code[CODE_IALU]) begin
                sel = WB_SEL_ALU;
                we  = 1'b1;
            end
            if (code[CODE_LOAD]) begin
                sel     = WB_SEL_MEM;
                we      = 1'b1;
                is_load = 1'b1;
            end
`ifdef WB_CSR_EN
            if (code[CODE_CSR]) begin
                sel = WB_SEL_CSR;
                we  = 1'b1;
            end
`endif
        end

        // x0 is hardwired, so nothing ever writes it.
        if (rd == '0) we = 1'b0;
    end

endmodule

// File: rtl/wb_sel_pipe.sv
// Writeback-select pipe: decodes at input, carries entries DEPTH stages, holds loads for memory.
// Optional feature macro: WB_CSR_EN (requires SEL_W >= 3).
module wb_sel_pipe
    import wb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int SEL_W    = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [9:0]       in_code,
    input  logic [4:0]       in_rd,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_we,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic             load_err,
    output logic             busy
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("wb_sel_pipe: DEPTH must be at least 1");
        end
        if (MAX_WAIT < 1) begin : g_bad_wait
            $error("wb_sel_pipe: MAX_WAIT must be at least 1");
        end
        if (SEL_W < 1 || SEL_W > WB_SEL_MAX_W) begin : g_bad_sel
            $error("wb_sel_pipe: SEL_W out of range");
        end
`ifdef WB_CSR_EN
        if (SEL_W < 3) begin : g_bad_csr_sel
            $error("wb_sel_pipe: WB_CSR_EN needs SEL_W >= 3");
        end
`endif
    endgenerate

    logic [WB_SEL_MAX_W-1:0] dec_sel;
    logic                    dec_we;
    logic                    dec_load;
    logic                    dec_ill;
    wb_entry_t               dec_p0;

    wb_decode u_decode (
        .code    (in_code),
        .rd      (in_rd),
        .sel     (dec_sel),
        .we      (dec_we),
        .is_load (dec_load),
        .illegal (dec_ill)
    );

    assign dec_p0 = '{valid: in_valid, sel: dec_sel, we: dec_we, rd: in_rd,
                      is_load: dec_load, illegal: dec_ill};

    wb_entry_t               stg_p [DEPTH];
    wb_entry_t               last;
    logic [WB_SEL_MAX_W-1:0] last_sel;
    wb_state_t               state;
    wb_state_t               state_nxt;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    ld_done;

    logic kill;
    logic last_load;
    logic timeout;
    logic load_done;
    logic load_avail;
    logic hold;
    logic advance;
    logic commit;
    logic err_c;

    assign last     = stg_p[DEPTH-1];
    assign last_sel = last.sel;

    always_comb begin
        kill       = flush | reset;
        last_load  = last.valid & last.is_load;
        timeout    = (state == ST_LOAD_WAIT) && (wait_cnt >= CNT_W'(MAX_WAIT));
        load_done  = mem_ready | ld_done;
        // Outside LOAD_WAIT only a same-cycle mem_ready lets a load through.
        load_avail = (state == ST_LOAD_WAIT) ? (load_done | timeout) : mem_ready;
        hold       = last_load & ~load_avail;
        advance    = ~stall & ~hold;
        commit     = last.valid & advance & ~kill;
        err_c      = (state == ST_LOAD_WAIT) & timeout & ~load_done;
    end

    assign in_ready    = advance & ~kill;
    assign out_valid   = commit;
    assign out_sel     = commit ? SEL_W'(last_sel) : '0;
    assign out_we      = commit & last.we & ~err_c;
    assign out_rd      = commit ? last.rd : '0;
    assign out_illegal = commit & last.illegal;
    assign load_err    = commit & err_c;
    assign busy        = (state == ST_LOAD_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (last_load & ~mem_ready) state_nxt = ST_LOAD_WAIT;
            ST_LOAD_WAIT: if (commit) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Wait counter saturates at MAX_WAIT so long stalls cannot wrap it.
    always_ff @(posedge clk) begin
        if (kill || state != ST_LOAD_WAIT || commit) begin
            wait_cnt <= '0;
            ld_done  <= 1'b0;
        end else begin
            if (wait_cnt < CNT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + CNT_W'(1);
            if (stall & mem_ready) ld_done <= 1'b1;
        end
    end

    // Stage p0 .. p(DEPTH-1) boundary: only valids are reset, payload loads on advance.
    always_ff @(posedge clk) begin
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) stg_p[i].valid <= 1'b0;
        end else if (advance) begin
            stg_p[0] <= dec_p0;
            for (int i = 1; i < DEPTH; i++) stg_p[i] <= stg_p[i-1];
        end
    end

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Randomized self-checking bench for wb_sel_pipe against a slot-list reference model.
// Honors WB_CSR_EN (builds the DUT with SEL_W=3 when defined).
module tb_wb_sel_pipe;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 3;
`ifdef WB_CSR_EN
    localparam int SEL_W  = 3;
    localparam int CSR_SEL = 4;
    localparam bit CSR_WE  = 1'b1;
`else
    localparam int SEL_W  = 2;
    localparam int CSR_SEL = 0;
    localparam bit CSR_WE  = 1'b0;
`endif

    localparam logic [9:0] C_J   = 10'h001;
    localparam logic [9:0] C_LUI = 10'h004;
    localparam logic [9:0] C_B   = 10'h010;
    localparam logic [9:0] C_R   = 10'h020;
    localparam logic [9:0] C_LD  = 10'h100;
    localparam logic [9:0] C_CSR = 10'h200;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [9:0]       in_code = '0;
    logic [4:0]       in_rd = '0;
    logic             in_ready;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             mem_ready = 1'b0;
    logic             out_valid;
    logic [SEL_W-1:0] out_sel;
    logic             out_we;
    logic [4:0]       out_rd;
    logic             out_illegal;
    logic             load_err;
    logic             busy;

    wb_sel_pipe #(.DEPTH(DEPTH), .SEL_W(SEL_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code), .in_rd(in_rd),
        .in_ready(in_ready), .stall(stall), .flush(flush), .mem_ready(mem_ready),
        .out_valid(out_valid), .out_sel(out_sel), .out_we(out_we), .out_rd(out_rd),
        .out_illegal(out_illegal), .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: ordered slots (index DEPTH-1 is oldest) plus load-wait bookkeeping.
    bit         m_v    [DEPTH];
    logic [9:0] m_code [DEPTH];
    logic [4:0] m_rd   [DEPTH];
    bit         m_wait    = 0;
    bit         m_latched = 0;
    int         m_waited  = 0;

    logic o_v, o_we, o_ill, o_err, o_busy, o_rdy;
    logic [4:0] o_rd;
    int         o_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_dec(input logic [9:0] c, input logic [4:0] rd,
                                    output int sel, output bit we, output bit ill);
        int sel_tab [10];
        bit we_tab  [10];
        sel_tab = '{3, 3, 1, 2, 0, 2, 0, 2, 0, CSR_SEL};
        we_tab  = '{1, 1, 1, 1, 0, 1, 0, 1, 1, CSR_WE};
        sel = 0; we = 0; ill = 0;
        if ($countones(c) != 1) ill = 1;
        else for (int i = 0; i < 10; i++)
            if (c[i]) begin sel = sel_tab[i]; we = we_tab[i] && (rd != 0); end
    endfunction

    task automatic step(input logic iv, input logic [9:0] ic, input logic [4:0] ird,
                        input logic st, input logic fl, input logic mr, input logic rs);
        bit is_load, done, tmo, avail, adv, kill, e_v, err, dwe, dill;
        int dsel;
        @(negedge clk);
        in_valid = iv; in_code = ic; in_rd = ird;
        stall = st; flush = fl; mem_ready = mr; reset = rs;
        #1;
        o_v = out_valid; o_sel = int'(out_sel); o_we = out_we; o_rd = out_rd;
        o_ill = out_illegal; o_err = load_err; o_busy = busy; o_rdy = in_ready;

        is_load = m_v[DEPTH-1] && (m_code[DEPTH-1] == C_LD);
        done    = mr || m_latched;
        tmo     = m_waited >= MAX_WAIT;
        avail   = m_wait ? (done || tmo) : mr;
        adv     = !st && !(is_load && !avail);
        kill    = fl || rs;
        e_v     = m_v[DEPTH-1] && adv && !kill;
        err     = m_wait && tmo && !done;
        ref_dec(m_code[DEPTH-1], m_rd[DEPTH-1], dsel, dwe, dill);

        check("m_ready", o_rdy, adv && !kill);
        check("m_busy",  o_busy, m_wait);
        check("m_valid", o_v, e_v);
        check("m_sel",   o_sel, e_v ? dsel : 0);
        check("m_we",    o_we, e_v && dwe && !err);
        check("m_rd",    o_rd, e_v ? m_rd[DEPTH-1] : 5'd0);
        check("m_ill",   o_ill, e_v && dill);
        check("m_lerr",  o_err, e_v && err);

        @(posedge clk);
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
            m_wait = 0; m_waited = 0; m_latched = 0;
        end else begin
            if (m_wait) begin
                if (adv) begin m_wait = 0; m_waited = 0; m_latched = 0; end
                else begin
                    m_waited++;
                    if (st && mr) m_latched = 1;
                end
            end else if (is_load && !mr) begin
                m_wait = 1; m_waited = 0;
            end
            if (adv) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    m_v[i] = m_v[i-1]; m_code[i] = m_code[i-1]; m_rd[i] = m_rd[i-1];
                end
                m_v[0] = iv; m_code[0] = ic; m_rd[0] = ird;
            end
        end
    endtask

    task automatic idle(input logic st, input logic mr);
        step(1'b0, 10'd0, 5'd0, st, 1'b0, mr, 1'b0);
    endtask

    initial begin
        int mr_bias;
        logic [9:0] c;
        int r;
        for (int i = 0; i < DEPTH; i++) begin m_v[i] = 0; m_code[i] = '0; m_rd[i] = '0; end

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        check("rst_ready", o_rdy, 1);
        check("rst_valid", o_v, 0);
        check("rst_busy", o_busy, 0);

        // Basic latency and back-to-back
        step(1, C_R, 5, 0, 0, 0, 0);
        step(1, C_LUI, 1, 0, 0, 0, 0);
        check("lat_early", o_v, 0);
        step(1, C_B, 3, 0, 0, 0, 0);
        check("lat_valid", o_v, 1);
        check("lat_sel", o_sel, 2);
        check("lat_we", o_we, 1);
        check("lat_rd", o_rd, 5);
        idle(0, 0);
        check("lui_sel", o_sel, 1);
        check("lui_we", o_we, 1);
        idle(0, 0);
        check("b_valid", o_v, 1);
        check("b_we", o_we, 0);

        // rd=0 and illegal code
        step(1, C_J, 0, 0, 0, 0, 0);
        step(1, 10'h003, 4, 0, 0, 0, 0);
        idle(0, 0);
        check("jal0_sel", o_sel, 3);
        check("jal0_we", o_we, 0);
        idle(0, 0);
        check("ill_flag", o_ill, 1);
        check("ill_we", o_we, 0);

        // Load wait then mem_ready
        step(1, C_LD, 9, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        check("ldw_hold_rdy", o_rdy, 0);
        idle(0, 0);
        check("ldw_busy", o_busy, 1);
        check("ldw_rdy", o_rdy, 0);
        idle(0, 0);
        idle(0, 1);
        check("ldw_valid", o_v, 1);
        check("ldw_sel", o_sel, 0);
        check("ldw_we", o_we, 1);
        check("ldw_rd", o_rd, 9);
        idle(0, 0);
        check("ldw_busy_clr", o_busy, 0);

        // Timeout: commit MAX_WAIT+1 cycles after reaching the last stage
        step(1, C_LD, 10, 0, 0, 0, 0);
        repeat (4) idle(0, 0);
        idle(0, 0);
        check("tmo_early", o_v, 0);
        idle(0, 0);
        check("tmo_valid", o_v, 1);
        check("tmo_err", o_err, 1);
        check("tmo_we", o_we, 0);

        // Latched completion under stall
        step(1, C_LD, 11, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        idle(1, 1);
        check("latc_hold", o_v, 0);
        idle(1, 0);
        idle(0, 0);
        check("latc_valid", o_v, 1);
        check("latc_we", o_we, 1);
        check("latc_err", o_err, 0);
        check("latc_rd", o_rd, 11);

        // Flush during LOAD_WAIT with entries behind
        step(1, C_LD, 12, 0, 0, 0, 0);
        step(1, C_R, 13, 0, 0, 0, 0);
        step(1, C_R, 14, 0, 0, 0, 0);
        step(1, C_R, 14, 0, 0, 0, 0);
        check("fl_busy_pre", o_busy, 1);
        step(1, C_R, 15, 0, 1, 1, 0);
        check("fl_valid", o_v, 0);
        check("fl_ready", o_rdy, 0);
        idle(0, 0);
        check("fl_busy", o_busy, 0);
        check("fl_none1", o_v, 0);
        idle(0, 0);
        check("fl_none2", o_v, 0);

        // CSR class
        step(1, C_CSR, 7, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        check("csr_valid", o_v, 1);
        check("csr_sel", o_sel, CSR_SEL);
        check("csr_we", o_we, CSR_WE);
        check("csr_ill", o_ill, 0);

        // Randomized traffic
        mr_bias = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                r = $urandom_range(0, 2);
                mr_bias = (r == 0) ? 0 : (r == 1) ? 2 : 9;
            end
            r = $urandom_range(0, 9);
            if (r < 1)      c = 10'($urandom_range(0, 1023));
            else if (r < 4) c = C_LD;
            else begin
                c = 10'd1;
                c = c << $urandom_range(0, 9);
            end
            step($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0,
                 $urandom_range(0, mr_bias) == 0, $urandom_range(0, 400) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
